// File: rtl/wb_drain_ctrl_if.sv
// Column-FIFO read side plus the shared writeback port of the drain controller.
// master = controller view, slave = FIFO bank / writeback sink view.
interface wb_drain_ctrl_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH*DATA_W-1:0] fifo_rdata;
  logic [NUM_CH-1:0]        fifo_rd_en;
  logic                     wb_valid;
  logic                     wb_ready;
  logic [DATA_W-1:0]        wb_data;
  logic [CH_W-1:0]          wb_ch;

  modport master (
    input  fifo_empty, fifo_rdata, wb_ready,
    output fifo_rd_en, wb_valid, wb_data, wb_ch
  );

  modport slave (
    output fifo_empty, fifo_rdata, wb_ready,
    input  fifo_rd_en, wb_valid, wb_data, wb_ch
  );
endinterface

// File: rtl/wb_drain_ctrl.sv
// Writeback drain controller: round-robin over the column FIFOs, moving up to
// BURST beats per grant onto the shared valid/ready writeback port until every
// FIFO is empty, then pulsing done.

// Per-channel slice: selects this channel's head data and pop strobe when it
// owns the current burst.
module wb_drain_lane #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 2,
  parameter int CH_IDX = 0
) (
  input  logic              xfer,
  input  logic              en,
  input  logic              wb_ready,
  input  logic [CH_W-1:0]   wb_ch,
  input  logic              empty,
  input  logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              vld,
  output logic              pop,
  output logic [DATA_W-1:0] data
);
  assign sel  = (wb_ch == CH_W'(CH_IDX));
  assign vld  = sel & xfer & en & ~empty;
  // pop only on an accepted beat, so a stalled or paused beat stays in the FIFO
  assign pop  = vld & wb_ready;
  assign data = sel ? rdata : '0;
endmodule

module wb_drain_ctrl #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16,
  parameter int BURST  = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               en,
  wb_drain_ctrl_if.master    bus,
  output logic               busy,
  output logic               done
);
  localparam int CNT_W = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   wb_ch_q, wb_ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic                           xfer;
  logic [NUM_CH-1:0]              lane_sel;
  logic [NUM_CH-1:0]              lane_vld;
  logic [NUM_CH-1:0]              lane_pop;
  logic [NUM_CH-1:0][DATA_W-1:0]  lane_data;
  logic [DATA_W-1:0]              wb_data_c;
  logic                           cur_empty;

  logic [NUM_CH-1:0] req;
  logic [CH_W:0]     arb_idx;
  logic              grant_vld;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   ptr_nxt;

  assign xfer = (state_q == S_XFER);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    wb_drain_lane #(
      .DATA_W (DATA_W),
      .CH_W   (CH_W),
      .CH_IDX (gi)
    ) u_lane (
      .xfer     (xfer),
      .en       (en),
      .wb_ready (bus.wb_ready),
      .wb_ch    (wb_ch_q),
      .empty    (bus.fifo_empty[gi]),
      .rdata    (bus.fifo_rdata[gi*DATA_W +: DATA_W]),
      .sel      (lane_sel[gi]),
      .vld      (lane_vld[gi]),
      .pop      (lane_pop[gi]),
      .data     (lane_data[gi])
    );
  end

  // OR-reduce the per-lane masked data; exactly one lane is selected
  always_comb begin
    wb_data_c = '0;
    for (int i = 0; i < NUM_CH; i++) wb_data_c = wb_data_c | lane_data[i];
  end

  assign cur_empty      = |(lane_sel & bus.fifo_empty);
  assign bus.wb_valid   = |lane_vld;
  assign bus.fifo_rd_en = lane_pop;
  assign bus.wb_data    = wb_data_c;
  assign bus.wb_ch      = wb_ch_q;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // channel after the one just served becomes highest priority
  assign ptr_nxt = (wb_ch_q == CH_W'(NUM_CH - 1)) ? '0 : wb_ch_q + CH_W'(1);

  // round-robin search: first requesting channel at or above ptr, wrapping
  always_comb begin
    req       = ~bus.fifo_empty;
    grant_vld = 1'b0;
    grant     = '0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_idx = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (arb_idx >= (CH_W+1)'(NUM_CH)) arb_idx = arb_idx - (CH_W+1)'(NUM_CH);
      if (!grant_vld && req[arb_idx[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = arb_idx[CH_W-1:0];
      end
    end
  end

  // next-state: arbitrate, run a burst, repeat until nothing requests
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wb_ch_d = wb_ch_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_ARB;
      S_ARB: begin
        if (en) begin
          if (grant_vld) begin
            wb_ch_d = grant;
            cnt_d   = '0;
            state_d = S_XFER;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_XFER: begin
        if (en) begin
          if (cur_empty) begin
            // source ran dry before the burst limit: give up the grant
            state_d = S_ARB;
            ptr_d   = ptr_nxt;
          end else if (bus.wb_ready) begin
            if (cnt_q == CNT_W'(BURST - 1)) begin
              state_d = S_ARB;
              ptr_d   = ptr_nxt;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers; ptr survives between drains and is cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      wb_ch_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wb_ch_q <= wb_ch_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Bench for wb_drain_ctrl: behavioural FIFO bank, transaction-level round-robin
// model of the expected beat stream, and scenario tasks.
module tb_wb_drain_ctrl;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int BURST  = 4;
  localparam int CH_W   = 2;
  localparam int DEPTH  = 128;

  logic clk, rstn, start, en, busy, done;

  wb_drain_ctrl_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  wb_drain_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BURST(BURST), .CH_W(CH_W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .en    (en),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO bank model: show-ahead, pop takes effect at the clock edge
  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  int rd_ptr [NUM_CH] = '{default: 0};
  int wr_ptr [NUM_CH] = '{default: 0};
  int uflow = 0;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
    assign bus.fifo_empty[gi] = (rd_ptr[gi] == wr_ptr[gi]);
    assign bus.fifo_rdata[gi*DATA_W +: DATA_W] = mem[gi][rd_ptr[gi] % DEPTH];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.fifo_rd_en[i]) begin
        if (rd_ptr[i] == wr_ptr[i]) uflow <= uflow + 1;
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  int                exp_ch[$];
  logic [DATA_W-1:0] exp_data[$];
  int                obs_ch[$];
  logic [DATA_W-1:0] obs_data[$];
  int model_ptr = 0;
  int exp_done_off;
  int done_cnt, done_t, pops, stab_err, pop_err, pause_err, timed_out;

  task automatic push(input int ch, input logic [DATA_W-1:0] d);
    mem[ch][wr_ptr[ch]] = d;
    wr_ptr[ch]++;
  endtask

  task automatic load(input int ch, input int n);
    for (int i = 0; i < n; i++) push(ch, DATA_W'($urandom));
  endtask

  // Transaction model: serve the first non-empty channel from the priority
  // pointer, up to BURST entries, then rotate priority past it. Also derives
  // the cycle (relative to the start edge) where done appears: one ARB cycle
  // per grant, one cycle per beat, one extra cycle when a burst ends short.
  task automatic build_expected();
    int rem[NUM_CH];
    int hd[NUM_CH];
    int p, off, c, n;
    exp_ch.delete();
    exp_data.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      rem[i] = wr_ptr[i] - rd_ptr[i];
      hd[i]  = rd_ptr[i];
    end
    p   = model_ptr;
    off = 1;
    while (1) begin
      c = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int j;
        j = (p + k) % NUM_CH;
        if (c < 0 && rem[j] > 0) c = j;
      end
      if (c < 0) break;
      n = (rem[c] < BURST) ? rem[c] : BURST;
      for (int j = 0; j < n; j++) begin
        exp_ch.push_back(c);
        exp_data.push_back(mem[c][hd[c] + j]);
      end
      hd[c]  += n;
      rem[c] -= n;
      off    += n + ((n < BURST) ? 1 : 0) + 1;
      p       = (c + 1) % NUM_CH;
    end
    exp_done_off = off + 1;
    model_ptr    = p;
  endtask

  function automatic int seq_mismatch();
    int m;
    m = 0;
    if (obs_ch.size() != exp_ch.size()) return 1000 + obs_ch.size();
    for (int i = 0; i < obs_ch.size(); i++)
      if (obs_ch[i] != exp_ch[i] || obs_data[i] !== exp_data[i]) m++;
    return m;
  endfunction

  // Pulse start, then observe every cycle until done plus a short tail.
  task automatic run_drain(input int ready_rand, input int pause_at, input int ign_t);
    int t;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic [CH_W-1:0]   prev_ch;
    obs_ch.delete();
    obs_data.delete();
    done_cnt = 0; done_t = -1; pops = 0; stab_err = 0; pop_err = 0;
    pause_err = 0; timed_out = 0;
    prev_stall = 1'b0; prev_data = '0; prev_ch = '0;
    build_expected();
    @(negedge clk);
    start = 1'b1; en = 1'b1; bus.wb_ready = 1'b1;
    @(negedge clk);
    t = 1;
    while (t < 2000) begin
      start = (t == ign_t);
      en = !(pause_at > 0 && t >= pause_at && t < pause_at + 5);
      bus.wb_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!en && (bus.wb_valid || bus.fifo_rd_en != '0)) pause_err++;
      pops += $countones(bus.fifo_rd_en);
      if (bus.wb_valid && bus.wb_ready) begin
        obs_ch.push_back(int'(bus.wb_ch));
        obs_data.push_back(bus.wb_data);
        if (bus.fifo_rd_en != NUM_CH'(1 << bus.wb_ch)) pop_err++;
      end else if (bus.fifo_rd_en != '0) begin
        pop_err++;
      end
      if (prev_stall && en && bus.wb_valid &&
          (bus.wb_data !== prev_data || bus.wb_ch !== prev_ch)) stab_err++;
      prev_stall = bus.wb_valid & ~bus.wb_ready;
      prev_data  = bus.wb_data;
      prev_ch    = bus.wb_ch;
      if (done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (done_t >= 0 && t >= done_t + 4) break;
      @(negedge clk);
      t++;
    end
    if (done_t < 0) timed_out = 1;
    start = 1'b0;
    en = 1'b1;
    bus.wb_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    int m;
    rstn = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, bus.wb_valid, bus.fifo_rd_en} !== '0) begin
      $display("FAIL reset_init: outputs=%b expected 0", {busy, done, bus.wb_valid, bus.fifo_rd_en});
    end else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    load(0, 6);
    load(1, 2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    // now mid-burst on ch0
    rstn = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_mid_busy: busy=%b done=%b expected 0", busy, done);
    end else n_pass++;
    n_chk++;
    if (bus.wb_valid !== 1'b0 || bus.fifo_rd_en !== '0) begin
      $display("FAIL reset_mid_port: wb_valid=%b rd_en=%b expected 0", bus.wb_valid, bus.fifo_rd_en);
    end else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    model_ptr = 0;
    run_drain(0, 0, 0);
    n_chk++;
    if (obs_ch.size() == 0 || obs_ch[0] != 0) begin
      $display("FAIL reset_first_grant: ch=%0d expected 0", (obs_ch.size() > 0) ? obs_ch[0] : -1);
    end else n_pass++;
    m = seq_mismatch();
    n_chk++;
    if (m != 0 || timed_out != 0) begin
      $display("FAIL reset_drain_seq: mismatches=%0d timeout=%0d expected 0", m, timed_out);
    end else n_pass++;
  endtask

  task automatic test_full_rr();
    int lit [18] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 0,0, 1,1, 2,2};
    int m;
    pulse_reset();
    for (int c = 0; c < NUM_CH; c++) load(c, 6);
    run_drain(0, 0, 0);
    m = 0;
    for (int i = 0; i < 18; i++) if (i >= obs_ch.size() || obs_ch[i] != lit[i]) m++;
    n_chk++;
    if (m != 0 || obs_ch.size() != 18) begin
      $display("FAIL rr_ch_order: bad=%0d beats=%0d expected 0/18", m, obs_ch.size());
    end else n_pass++;
    m = seq_mismatch();
    n_chk++;
    if (m != 0) $display("FAIL rr_data: mismatches=%0d expected 0", m);
    else n_pass++;
    n_chk++;
    if (pops != 18 || pop_err != 0) begin
      $display("FAIL rr_pops: pops=%0d pop_err=%0d expected 18/0", pops, pop_err);
    end else n_pass++;
    n_chk++;
    if (done_t != 29 || done_t != exp_done_off) begin
      $display("FAIL rr_done_cycle: got %0d expected %0d", done_t, exp_done_off);
    end else n_pass++;
    n_chk++;
    if (done_cnt != 1) $display("FAIL rr_done_once: got %0d expected 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_sparse();
    int m;
    load(1, 3);
    run_drain(0, 0, 0);
    m = seq_mismatch();
    n_chk++;
    if (m != 0 || obs_ch.size() != 3) begin
      $display("FAIL sparse_seq: mismatches=%0d beats=%0d expected 0/3", m, obs_ch.size());
    end else n_pass++;
    n_chk++;
    if (done_t != 7) $display("FAIL sparse_done_cycle: got %0d expected 7", done_t);
    else n_pass++;
    load(0, 2);
    load(2, 2);
    run_drain(0, 0, 0);
    n_chk++;
    if (obs_ch.size() == 0 || obs_ch[0] != 2) begin
      $display("FAIL sparse_next_ptr: first ch=%0d expected 2", (obs_ch.size() > 0) ? obs_ch[0] : -1);
    end else n_pass++;
    m = seq_mismatch();
    n_chk++;
    if (m != 0) $display("FAIL sparse_next_seq: mismatches=%0d expected 0", m);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int m;
    load(0, 5);
    load(1, 7);
    load(2, 3);
    run_drain(1, 0, 0);
    m = seq_mismatch();
    n_chk++;
    if (m != 0) $display("FAIL bp_order: mismatches=%0d expected 0", m);
    else n_pass++;
    n_chk++;
    if (stab_err != 0) $display("FAIL bp_stable: unstable stalls=%0d expected 0", stab_err);
    else n_pass++;
    n_chk++;
    if (pops != obs_ch.size() || pops != 15 || pop_err != 0) begin
      $display("FAIL bp_pops: pops=%0d beats=%0d pop_err=%0d expected 15/15/0", pops, obs_ch.size(), pop_err);
    end else n_pass++;
    n_chk++;
    if (done_cnt != 1 || timed_out != 0) begin
      $display("FAIL bp_done: done_cnt=%0d timeout=%0d expected 1/0", done_cnt, timed_out);
    end else n_pass++;
  endtask

  task automatic test_pause();
    int m;
    load(0, 6);
    load(1, 2);
    run_drain(0, 3, 0);
    n_chk++;
    if (pause_err != 0) $display("FAIL pause_quiet: activity cycles=%0d expected 0", pause_err);
    else n_pass++;
    m = seq_mismatch();
    n_chk++;
    if (m != 0) $display("FAIL pause_burst: mismatches=%0d expected 0", m);
    else n_pass++;
    n_chk++;
    if (done_t != exp_done_off + 5) begin
      $display("FAIL pause_done_cycle: got %0d expected %0d", done_t, exp_done_off + 5);
    end else n_pass++;
  endtask

  task automatic test_empty_start();
    run_drain(0, 0, 1);
    n_chk++;
    if (done_t != 2) $display("FAIL empty_done_cycle: got %0d expected 2", done_t);
    else n_pass++;
    n_chk++;
    if (done_cnt != 1) $display("FAIL empty_ignored_start: done pulses=%0d expected 1", done_cnt);
    else n_pass++;
    n_chk++;
    if (obs_ch.size() != 0 || busy !== 1'b0) begin
      $display("FAIL empty_idle: beats=%0d busy=%b expected 0/0", obs_ch.size(), busy);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int m;
    for (int c = 0; c < NUM_CH; c++) load(c, $urandom_range(0, 9));
    run_drain(1, 0, 0);
    m = seq_mismatch();
    n_chk++;
    if (m != 0 || timed_out != 0) begin
      $display("FAIL b2b_seq: mismatches=%0d timeout=%0d expected 0", m, timed_out);
    end else n_pass++;
    n_chk++;
    if (uflow != 0) $display("FAIL no_underflow: empty pops=%0d expected 0", uflow);
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    start = 1'b0;
    en = 1'b1;
    bus.wb_ready = 1'b1;
    rstn = 1'b0;
    test_reset();
    test_full_rr();
    test_sparse();
    test_backpressure();
    test_pause();
    test_empty_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
